vblank_update_scheduler: RTL and testbench



---
 rtl/vblank_sched_pkg.sv | 44 ++++
 rtl/vblank_update_scheduler_rr_pick.sv | 31 +++
 rtl/vblank_update_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_vblank_update_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vblank_sched_pkg.sv
// vblank_sched_pkg
// Shared types and constants for the vblank update scheduler.
//   sched_state_t : scheduler FSM state encoding
//   DEF_*         : default parameter values
//   MAX_REQ/IDX_W : widest supported requester count and its index width
//   rr_next_idx() : round-robin search, first set bit of mask at or after ptr
package vblank_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    SCAN    = 2'd2,
    GRANT   = 2'd3
  } sched_state_t;

  localparam int unsigned DEF_NUM_REQ       = 4;
  localparam int unsigned DEF_GRANT_TIMEOUT = 64;
  localparam int unsigned DEF_MIN_SLACK     = 8;
  localparam int unsigned MAX_REQ           = 8;
  localparam int unsigned IDX_W             = 3;

  // Bits at or above n are never considered; ptr is expected to be below n.
  function automatic logic [IDX_W-1:0] rr_next_idx(
    input logic [MAX_REQ-1:0] mask,
    input logic [IDX_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    int unsigned      j;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if ((i < n) && !found && mask[j[IDX_W-1:0]]) begin
        idx   = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vblank_update_scheduler_rr_pick.sv
// rr_pick
// Combinational round-robin picker.
//   i_pending : requests still eligible this frame
//   i_ptr     : index with highest priority
//   o_onehot  : one-hot of the chosen requester (zero when nothing pending)
//   o_idx     : index of the chosen requester
//   o_valid   : at least one pending request
module rr_pick
  import vblank_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] w_mask;

  always_comb begin
    w_mask                = '0;
    w_mask[NUM_REQ-1:0]   = i_pending;
  end

  assign o_idx    = rr_next_idx(w_mask, i_ptr, NUM_REQ);
  assign o_valid  = |i_pending;
  assign o_onehot = o_valid ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
// Hands the per-frame state-update slot to one requester at a time, only
// while the video timer is in vertical blanking.
//
// Ports
//   i_clk            pixel clock
//   i_rst_n          synchronous active-low reset
//   i_frame[31:0]    frame counter; any change starts a new frame window
//   i_in_vblank      high during vertical blanking
//   i_vblank_left    blanking cycles remaining (valid while in vblank)
//   i_req[N-1:0]     level requests, held until granted and done
//   i_done[N-1:0]    one-cycle completion pulse from the granted requester
//   o_grant[N-1:0]   one-hot registered grant
//   o_busy           FSM not idle
//   o_overrun        pulse: window closed / new frame with work unserved
//   o_timeout        pulse: grant force-released by the timer
//   o_overrun_count  (SCHED_STATS_EN) saturating count of overrun pulses
//   o_timeout_count  (SCHED_STATS_EN) saturating count of timeout pulses
//
// Build option: define SCHED_STATS_EN to add the two statistics counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | frame served or abandoned; waiting for the frame counter
// WAIT_VB | new frame seen; waiting for vertical blanking
// SCAN    | one-cycle decision: grant next, finish, or report overrun
// GRANT   | one requester owns the slot; waiting for done or timeout
module vblank_update_scheduler
  import vblank_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int unsigned MIN_SLACK     = DEF_MIN_SLACK
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_frame,
  input  logic               i_in_vblank,
  input  logic [15:0]        i_vblank_left,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_done,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]        o_overrun_count,
  output logic [15:0]        o_timeout_count
`endif
);

  localparam int unsigned TMR_W = $clog2(GRANT_TIMEOUT + 1);

  sched_state_t       r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic               r_overrun;
  logic               r_timeout;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_cur_ptr;
  logic [IDX_W-1:0]   r_gidx;
  logic [31:0]        r_frame_prev;
  logic [NUM_REQ-1:0] r_served;
  logic [TMR_W-1:0]   r_timer;

  logic [NUM_REQ-1:0] w_pending;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic               w_new_frame;
  logic               w_done_hit;
  logic               w_no_slack;
  logic [TMR_W-1:0]   w_timer_dec;
  logic               w_timer_tc;
  logic [IDX_W-1:0]   w_ptr_inc;

  assign w_pending   = i_req & ~r_served;
  assign w_new_frame = (i_frame != r_frame_prev);
  // Only the granted requester's done counts; stray pulses are dropped here.
  assign w_done_hit  = |(i_done & r_grant);
  assign w_no_slack  = !i_in_vblank || (i_vblank_left < 16'(MIN_SLACK));
  assign w_timer_dec = (r_timer == '0) ? '0 : r_timer - 1'b1;
  assign w_timer_tc  = (w_timer_dec == '0);
  assign w_ptr_inc   = (r_rr_ptr == IDX_W'(NUM_REQ - 1)) ? '0 : r_rr_ptr + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_pending (w_pending),
    .i_ptr     (r_cur_ptr),
    .o_onehot  (w_pick_onehot),
    .o_idx     (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  // r_cur_ptr is the priority used for the whole current frame; r_rr_ptr is
  // already advanced for the next one, so reset serves index 0 first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_rr_ptr     <= '0;
      r_cur_ptr    <= '0;
      r_gidx       <= '0;
      r_frame_prev <= i_frame;
      r_served     <= '0;
      r_timer      <= '0;
    end else begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      if (w_new_frame) begin
        // A frame change always restarts the window, whatever was in flight.
        r_frame_prev <= i_frame;
        r_served     <= '0;
        r_grant      <= '0;
        r_cur_ptr    <= r_rr_ptr;
        r_rr_ptr     <= w_ptr_inc;
        r_state      <= WAIT_VB;
        r_busy       <= 1'b1;
        if (r_state != IDLE) r_overrun <= |w_pending;
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          WAIT_VB: begin
            if (i_in_vblank) r_state <= SCAN;
          end
          SCAN: begin
            if (!w_pick_valid) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (w_no_slack) begin
              r_overrun <= 1'b1;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_grant <= w_pick_onehot;
              r_gidx  <= w_pick_idx;
              r_timer <= TMR_W'(GRANT_TIMEOUT);
              r_state <= GRANT;
            end
          end
          GRANT: begin
            // done wins over a simultaneous timer expiry
            if (w_done_hit || w_timer_tc) begin
              r_timeout <= !w_done_hit;
              r_served  <= r_served | (NUM_REQ'(1) << r_gidx);
              r_grant   <= '0;
              r_state   <= SCAN;
            end else begin
              r_timer <= w_timer_dec;
            end
          end
          default: begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_grant   = r_grant;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;
  assign o_timeout = r_timeout;

`ifdef SCHED_STATS_EN
  logic [15:0] r_overrun_count;
  logic [15:0] r_timeout_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_overrun_count <= '0;
      r_timeout_count <= '0;
    end else begin
      if (r_overrun && (r_overrun_count != 16'hFFFF))
        r_overrun_count <= r_overrun_count + 1'b1;
      if (r_timeout && (r_timeout_count != 16'hFFFF))
        r_timeout_count <= r_timeout_count + 1'b1;
    end
  end

  assign o_overrun_count = r_overrun_count;
  assign o_timeout_count = r_timeout_count;
`endif

endmodule

// File: tb/tb_vblank_update_scheduler.sv
module tb_vblank_update_scheduler;

  logic        clk;
  logic        rst_n;
  logic [31:0] frame;
  logic        in_vblank;
  logic [15:0] vbl;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [3:0]  grant;
  logic        busy;
  logic        overrun;
  logic        timeout;
`ifdef SCHED_STATS_EN
  logic [15:0] ov_cnt;
  logic [15:0] to_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;   // priority index the next frame will start from
  int exp_ov = 0;
  int exp_to = 0;
  int dly[4];        // cycles from grant to done per requester; >63 means never
  bit noise_en = 0;

  vblank_update_scheduler dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame       (frame),
    .i_in_vblank   (in_vblank),
    .i_vblank_left (vbl),
    .i_req         (req),
    .i_done        (done),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_timeout     (timeout)
`ifdef SCHED_STATS_EN
    ,
    .o_overrun_count (ov_cnt),
    .o_timeout_count (to_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_pick(input logic [3:0] m, input int p);
    for (int i = 0; i < 4; i++) if (m[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // One frame window. Builds the expected grant schedule from the latency
  // rules (first grant 3 cycles after the frame change, or 2 after vblank
  // rises; next grant 2 cycles after done; timeout after 64 granted cycles),
  // then steps the clock comparing every output on every cycle.
  task automatic run_frame(input logic [3:0] rq, input int v0, input bit vdec,
                           input int vb_k);
    int gs[4], ge[4], gi[4];
    bit gd[4];
    int to_t[4];
    int ng, n_to, ov_t, t, ptr, idx, d, vs, t_end;
    logic [3:0] served, rem, eg, dn;
    bit eto;
    ptr = exp_ptr;
    exp_ptr = (exp_ptr + 1) % 4;
    ng = 0; n_to = 0; ov_t = -1; served = 4'b0;
    t = ((vb_k < 1) ? 1 : vb_k) + 2;
    for (int k = 0; k < 5; k++) begin
      rem = rq & ~served;
      if (rem == 4'b0) break;
      vs = vdec ? ((v0 - (t - 1)) > 0 ? v0 - (t - 1) : 0) : v0;
      if (vs < 8) begin ov_t = t; break; end
      idx = ref_pick(rem, ptr);
      d = dly[idx];
      gs[ng] = t; gi[ng] = idx;
      if (d <= 63) begin
        ge[ng] = t + d; gd[ng] = 1'b1; t = t + d + 2;
      end else begin
        ge[ng] = t + 63; gd[ng] = 1'b0; to_t[n_to] = t + 64; n_to++; t = t + 65;
      end
      ng++;
      served[idx] = 1'b1;
    end
    t_end = t;
    if (ov_t >= 0) exp_ov++;
    exp_to += n_to;

    @(negedge clk);
    frame = frame + 32'd1 + 32'($urandom_range(0, 100));
    req = rq;
    in_vblank = (vb_k == 0);
    vbl = 16'(v0);
    done = 4'b0;
    for (int c = 1; c <= t_end + 2; c++) begin
      @(negedge clk);
      eg = 4'b0; dn = 4'b0; eto = 1'b0;
      for (int k = 0; k < ng; k++) begin
        if (c >= gs[k] && c <= ge[k]) eg = 4'b1 << gi[k];
        if (gd[k] && c == ge[k]) dn = 4'b1 << gi[k];
      end
      for (int k = 0; k < n_to; k++) if (c == to_t[k]) eto = 1'b1;
      tests++;
      if (grant !== eg) begin
        fails++; $display("FAIL grant c=%0d got=%b exp=%b", c, grant, eg);
      end
      tests++;
      if (busy !== (c < t_end)) begin
        fails++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, c < t_end);
      end
      tests++;
      if (overrun !== (c == ov_t)) begin
        fails++; $display("FAIL overrun c=%0d got=%b exp=%b", c, overrun, c == ov_t);
      end
      tests++;
      if (timeout !== eto) begin
        fails++; $display("FAIL timeout c=%0d got=%b exp=%b", c, timeout, eto);
      end
      if (noise_en) dn = dn | (4'($urandom) & ~eg);
      done = dn;
      in_vblank = (c >= vb_k);
      vbl = vdec ? 16'((v0 - c) > 0 ? v0 - c : 0) : 16'(v0);
    end
    done = 4'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame = 32'd5; in_vblank = 1'b1; vbl = 16'd1000;
    req = 4'($urandom); done = 4'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({grant, busy, overrun, timeout} !== 7'b0) begin
        fails++; $display("FAIL reset_outputs got=%b exp=0", {grant, busy, overrun, timeout});
      end
    end
    rst_n = 1'b1; req = 4'b0; done = 4'b0;
    exp_ptr = 0; exp_ov = 0; exp_to = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({grant, busy} !== 5'b0) begin
        fails++; $display("FAIL reset_idle got=%b exp=0", {grant, busy});
      end
    end
  endtask

  task automatic test_basic_grant();
    for (int i = 0; i < 4; i++) dly[i] = 4;
    noise_en = 0;
    run_frame(4'b1011, 1000, 1'b0, 0);
  endtask

  task automatic test_round_robin();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) dly[i] = int'($urandom_range(0, 5));
      run_frame(4'b1011, 1000, 1'b0, f);
    end
  endtask

  task automatic test_timeout();
    dly[0] = 1000;
    run_frame(4'b0001, 1000, 1'b0, 0);
  endtask

  task automatic test_window_close();
    for (int i = 0; i < 4; i++) dly[i] = 10;
    run_frame(4'b1111, 23, 1'b1, 0);
  endtask

  task automatic test_frame_change_granted();
    int p1, p2, i1, i2, i3;
    logic [3:0] e;
    p1 = exp_ptr; exp_ptr = (exp_ptr + 1) % 4;
    p2 = exp_ptr; exp_ptr = (exp_ptr + 1) % 4;
    i1 = ref_pick(4'b0011, p1);
    i2 = ref_pick(4'b0011, p2);
    e = 4'b0011;
    e[i2] = 1'b0;
    i3 = ref_pick(e, p2);
    @(negedge clk);
    frame = frame + 32'd1; req = 4'b0011; in_vblank = 1'b1; vbl = 16'd1000; done = 4'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      e = 4'b0;
      if (c >= 3 && c <= 8) e = 4'b1 << i1;
      if (c == 11) e = 4'b1 << i2;
      if (c == 13) e = 4'b1 << i3;
      tests++;
      if (grant !== e) begin
        fails++; $display("FAIL fc_grant c=%0d got=%b exp=%b", c, grant, e);
      end
      tests++;
      if (overrun !== (c == 9)) begin
        fails++; $display("FAIL fc_overrun c=%0d got=%b exp=%b", c, overrun, c == 9);
      end
      tests++;
      if (busy !== (c < 15)) begin
        fails++; $display("FAIL fc_busy c=%0d got=%b exp=%b", c, busy, c < 15);
      end
      done = 4'b0;
      if (c == 8) frame = frame + 32'd1;
      if (c == 11 || c == 13) done = e;
    end
    exp_ov++;
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk);
    frame = frame + 32'd1; req = 4'b0100; in_vblank = 1'b1; vbl = 16'd1000; done = 4'b0;
    exp_ptr = (exp_ptr + 1) % 4;
    repeat (3) @(negedge clk);
    tests++;
    if (grant !== 4'b0100) begin
      fails++; $display("FAIL rmg_pre got=%b exp=0100", grant);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0; exp_ov = 0; exp_to = 0;
    for (int c = 0; c < 70; c++) begin
      tests++;
      if ({grant, busy, overrun, timeout} !== 7'b0) begin
        fails++; $display("FAIL rmg_after c=%0d got=%b exp=0", c, {grant, busy, overrun, timeout});
      end
      @(negedge clk);
    end
    req = 4'b0;
  endtask

  task automatic test_random();
    bit vdec;
    int v0;
    noise_en = 1;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 4; i++)
        dly[i] = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 6));
      vdec = ($urandom_range(0, 3) == 0);
      v0 = vdec ? int'($urandom_range(5, 60)) : 1000;
      run_frame(4'($urandom_range(0, 15)), v0, vdec, int'($urandom_range(0, 3)));
    end
    noise_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_timeout();
    test_window_close();
    test_frame_change_granted();
    test_reset_mid_grant();
    test_random();
`ifdef SCHED_STATS_EN
    @(negedge clk);
    tests++;
    if (ov_cnt !== 16'(exp_ov)) begin
      fails++; $display("FAIL overrun_count got=%0d exp=%0d", ov_cnt, exp_ov);
    end
    tests++;
    if (to_cnt !== 16'(exp_to)) begin
      fails++; $display("FAIL timeout_count got=%0d exp=%0d", to_cnt, exp_to);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
